// File: rtl/alu_seq.sv
// Sequential 4-function ALU (add, sub, shift-add multiply, restoring divide) with hex display driver.
// Define ALU_SEQ_SSEG_EN to compile in the multiplexed seven-segment display; otherwise sseg/an stay dark.
module alu_seq #(
   parameter int WIDTH       = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           opcode,
   input  logic [WIDTH-1:0]     portA,
   input  logic [WIDTH-1:0]     portB,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 signoresta,
   output logic                 div_by_zero,
   output logic [0:6]           sseg,
   output logic [WIDTH/2-1:0]   an
);

   localparam int NDIG = WIDTH / 2;
   localparam int CW   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t               state;
   logic                 is_div;
   logic [WIDTH-1:0]     opnd;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic                 div_ge;
   logic [WIDTH:0]       div_rem;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd});
      div_rem   = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
      div_next  = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
      step_next = is_div ? div_next : mul_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         signoresta  <= 1'b0;
         div_by_zero <= 1'b0;
         is_div      <= 1'b0;
         opnd        <= '0;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy   <= 1'b1;
                  is_div <= opcode[0];
                  cnt    <= '0;
                  case (opcode)
                     2'd0: begin
                        result      <= {{WIDTH{1'b0}}, portA} + {{WIDTH{1'b0}}, portB};
                        signoresta  <= 1'b0;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                     end
                     2'd1: begin
                        if (portA >= portB) begin
                           result     <= {{WIDTH{1'b0}}, portA - portB};
                           signoresta <= 1'b0;
                        end else begin
                           result     <= {{WIDTH{1'b0}}, portB - portA};
                           signoresta <= 1'b1;
                        end
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                     end
                     2'd2: begin
                        acc   <= {{WIDTH{1'b0}}, portB};
                        opnd  <= portA;
                        state <= CALC;
                     end
                     default: begin
                        if (portB == '0) begin
                           result      <= '0;
                           signoresta  <= 1'b0;
                           div_by_zero <= 1'b1;
                           done        <= 1'b1;
                           state       <= FINISH;
                        end else begin
                           acc   <= {{WIDTH{1'b0}}, portA};
                           opnd  <= portB;
                           state <= CALC;
                        end
                     end
                  endcase
               end
            end
            CALC: begin
               acc <= step_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  result      <= step_next;
                  signoresta  <= 1'b0;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  state       <= FINISH;
               end
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_SSEG_EN
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [RW-1:0] refresh_cnt;
   logic [DW-1:0] dig;
   logic [3:0]    nib;

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         dig         <= '0;
      end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         dig         <= (dig == DW'(NDIG - 1)) ? '0 : dig + 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   always_comb begin
      nib = '0;
      an  = '1;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (dig == DW'(i)) begin
            nib   = result[4*i +: 4];
            an[i] = 1'b0;
         end
      end
   end

   // glyph literals are written a..g, left to right, active low
   always_comb begin
      case (nib)
         4'h0:    sseg = 7'b0000001;
         4'h1:    sseg = 7'b1001111;
         4'h2:    sseg = 7'b0010010;
         4'h3:    sseg = 7'b0000110;
         4'h4:    sseg = 7'b1001100;
         4'h5:    sseg = 7'b0100100;
         4'h6:    sseg = 7'b0100000;
         4'h7:    sseg = 7'b0001111;
         4'h8:    sseg = 7'b0000000;
         4'h9:    sseg = 7'b0000100;
         4'hA:    sseg = 7'b0001000;
         4'hB:    sseg = 7'b1100000;
         4'hC:    sseg = 7'b0110001;
         4'hD:    sseg = 7'b1000010;
         4'hE:    sseg = 7'b0110000;
         default: sseg = 7'b0111000;
      endcase
   end
`else
   assign sseg = '1;
   assign an   = '1;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=4, REFRESH_DIV=4); display checks follow ALU_SEQ_SSEG_EN.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] opcode = '0;
   logic [3:0] portA = '0;
   logic [3:0] portB = '0;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       signoresta;
   logic       div_by_zero;
   logic [0:6] sseg;
   logic [1:0] an;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .portA(portA), .portB(portB), .busy(busy), .done(done),
      .result(result), .signoresta(signoresta), .div_by_zero(div_by_zero),
      .sseg(sseg), .an(an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      opcode = op;
      portA  = a;
      portB  = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic idle_expect(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      logic [1:0] prev_an;
      bit         synced;

      // reset state
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 8'h00);
      check("rst_sign", signoresta, 0);
      check("rst_dbz", div_by_zero, 0);
`ifdef ALU_SEQ_SSEG_EN
      check("rst_an", an, 2'b10);
`else
      check("rst_an", an, 2'b11);
`endif
      rst = 1'b0;
      tick();

      // add 7+2
      launch(2'd0, 4'd7, 4'd2);
      check("add_done", done, 1);
      check("add_busy", busy, 1);
      check("add_result", result, 8'h09);
      check("add_sign", signoresta, 0);
      tick();
      idle_expect("add_after");
      check("add_hold", result, 8'h09);

      // subtract both directions
      launch(2'd1, 4'd2, 4'd7);
      check("sub_neg_done", done, 1);
      check("sub_neg_result", result, 8'h05);
      check("sub_neg_sign", signoresta, 1);
      tick();
      launch(2'd1, 4'd7, 4'd2);
      check("sub_pos_result", result, 8'h05);
      check("sub_pos_sign", signoresta, 0);
      tick();

      // multiply 15*15 with input changes and a stray start while busy
      launch(2'd2, 4'd15, 4'd15);
      check("mul_k1_busy", busy, 1);
      check("mul_k1_done", done, 0);
      portA = 4'd0; portB = 4'd0; opcode = 2'd0;
      tick();
      start = 1'b1;
      check("mul_k2_busy", busy, 1);
      check("mul_k2_done", done, 0);
      tick();
      start = 1'b0;
      check("mul_k3_done", done, 0);
      check("mul_k3_result", result, 8'h05);
      tick();
      check("mul_k4_done", done, 0);
      tick();
      check("mul_k5_done", done, 1);
      check("mul_k5_busy", busy, 1);
      check("mul_result", result, 8'hE1);
      check("mul_sign", signoresta, 0);
      tick();
      idle_expect("mul_k6");
      tick();
      check("mul_no_second_done", done, 0);
      check("mul_hold", result, 8'hE1);

      // display with E1 held: digit0 "1", digit1 "E"
      synced = 1'b0;
      for (int i = 0; i < 16 && !synced; i++) begin
         prev_an = an;
         tick();
`ifdef ALU_SEQ_SSEG_EN
         if (prev_an == 2'b01 && an == 2'b10) synced = 1'b1;
`else
         synced = 1'b1;
`endif
      end
      check("disp_sync", synced, 1);
      for (int j = 0; j < 8; j++) begin
`ifdef ALU_SEQ_SSEG_EN
         check("disp_an", an, (j < 4) ? 2'b10 : 2'b01);
         check("disp_sseg", sseg, (j < 4) ? 7'b1001111 : 7'b0110000);
`else
         check("disp_an_off", an, 2'b11);
         check("disp_sseg_off", sseg, 7'b1111111);
`endif
         tick();
      end

      // divide 7/2 -> q=3 r=1
      launch(2'd3, 4'd7, 4'd2);
      check("div_k1_busy", busy, 1);
      check("div_k1_done", done, 0);
      tick(); tick(); tick();
      check("div_k4_done", done, 0);
      tick();
      check("div_done", done, 1);
      check("div_result", result, 8'h13);
      check("div_dbz", div_by_zero, 0);
      tick();

      // divide 15/4 -> q=3 r=3
      launch(2'd3, 4'd15, 4'd4);
      tick(); tick(); tick(); tick();
      check("div2_done", done, 1);
      check("div2_result", result, 8'h33);
      tick();

      // divide by zero, then flags clear on later ops
      launch(2'd3, 4'd7, 4'd0);
      check("dbz_done", done, 1);
      check("dbz_result", result, 8'h00);
      check("dbz_flag", div_by_zero, 1);
      tick();
      idle_expect("dbz_after");
      launch(2'd1, 4'd2, 4'd7);
      check("dbz_clr_flag", div_by_zero, 0);
      check("dbz_clr_sign", signoresta, 1);
      tick();
      launch(2'd0, 4'd1, 4'd1);
      check("sign_clr", signoresta, 0);
      check("sign_clr_result", result, 8'h02);
      tick();

      // reset in the middle of a multiply
      launch(2'd2, 4'd3, 4'd5);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 8'h00);
      check("abort_sign", signoresta, 0);
      check("abort_dbz", div_by_zero, 0);
`ifdef ALU_SEQ_SSEG_EN
      check("abort_an", an, 2'b10);
`else
      check("abort_an", an, 2'b11);
`endif
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_done", done, 0);
      end
      launch(2'd0, 4'd3, 4'd4);
      check("post_abort_done", done, 1);
      check("post_abort_result", result, 8'h07);
      tick();

      // reset coincident with start wins
      rst = 1'b1;
      opcode = 2'd0; portA = 4'd5; portB = 4'd5; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      idle_expect("rst_start");
      check("rst_start_result", result, 8'h00);
      tick();
      idle_expect("rst_start_next");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
